// File: rtl/shift_sequencer_if.sv
// Handshake bundle for shift_sequencer.
// The master side (controller/testbench) drives load, len, hold and abort.
// The slave side (the sequencer) drives shift, wr, busy, cnt and err.
// Parameter CW: width of the length/count path.
interface shift_sequencer_if #(
  parameter int CW = 4
);
  logic          load;
  logic [CW-1:0] len;
  logic          hold;
  logic          abort;
  logic          shift;
  logic          wr;
  logic          busy;
  logic [CW-1:0] cnt;
  logic          err;

  modport master (
    output load, len, hold, abort,
    input  shift, wr, busy, cnt, err
  );

  modport slave (
    input  load, len, hold, abort,
    output shift, wr, busy, cnt, err
  );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: issues a burst of `len` shift enables after a load request.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - shift_sequencer_if.slave
//          in : load, len[CW-1:0], hold, abort
//          out: shift (combinational busy & ~hold), wr (one-cycle completion
//               strobe), busy (state RUN), cnt[CW-1:0] (remaining shifts),
//               err (one-cycle rejected-load pulse)
// Optional feature: define SHIFT_SEQ_PRELOAD_EN to add a one-deep pending
// length register so a load during a burst chains a second burst with no gap.
// Without it, any load while busy is rejected with err.
module shift_sequencer #(
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst,
  shift_sequencer_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt_q;
  logic          wr_q;
  logic          err_q;
  logic          last;

`ifdef SHIFT_SEQ_PRELOAD_EN
  logic [CW-1:0] pend_q;
  logic          pend_v;
`endif

  // Final shift of the current burst happens on this edge.
  always_comb last = (state == RUN) && !bus.hold && (cnt_q == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt_q  <= '0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
`ifdef SHIFT_SEQ_PRELOAD_EN
      pend_q <= '0;
      pend_v <= 1'b0;
`endif
    end else begin
      wr_q  <= 1'b0;
      err_q <= 1'b0;
      if (bus.abort) begin
        state  <= IDLE;
        cnt_q  <= '0;
`ifdef SHIFT_SEQ_PRELOAD_EN
        pend_v <= 1'b0;
`endif
      end else if (state == IDLE) begin
        if (bus.load) begin
          if (bus.len != '0) begin
            cnt_q <= bus.len;
            state <= RUN;
          end else begin
            err_q <= 1'b1;
          end
        end
      end else begin
        if (last) begin
          wr_q <= 1'b1;
`ifdef SHIFT_SEQ_PRELOAD_EN
          // Chain straight into the next burst: stored length first,
          // otherwise a load arriving on the completion edge itself.
          if (pend_v) begin
            cnt_q  <= pend_q;
            pend_v <= 1'b0;
          end else if (bus.load && (bus.len != '0)) begin
            cnt_q <= bus.len;
          end else begin
            state <= IDLE;
            cnt_q <= '0;
          end
`else
          state <= IDLE;
          cnt_q <= '0;
`endif
        end else if (!bus.hold) begin
          cnt_q <= cnt_q - CW'(1);
        end
`ifdef SHIFT_SEQ_PRELOAD_EN
        if (bus.load) begin
          if ((bus.len == '0) || pend_v) begin
            err_q <= 1'b1;
          end else if (!last) begin
            pend_q <= bus.len;
            pend_v <= 1'b1;
          end
        end
`else
        if (bus.load) err_q <= 1'b1;
`endif
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.shift = (state == RUN) && !bus.hold;
  assign bus.cnt   = cnt_q;
  assign bus.wr    = wr_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  shift_sequencer_if #(.CW(CW)) bus();

  shift_sequencer #(.CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs just after a rising edge, then stop at the following falling
  // edge where outputs reflect the state the next rising edge will act on.
  task automatic tick(input logic l, input logic [CW-1:0] n, input logic h, input logic a);
    @(posedge clk);
    #1;
    bus.load  = l;
    bus.len   = n;
    bus.hold  = h;
    bus.abort = a;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.load = 1'b1; bus.len = 4'd5; bus.hold = 1'b0; bus.abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.busy, bus.shift, bus.wr, bus.err, bus.cnt} !== {4'b0000, 4'd0}) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b shift=%b wr=%b err=%b cnt=%0d, required all 0",
               bus.busy, bus.shift, bus.wr, bus.err, bus.cnt);
    end
    bus.load = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int shifts = 0, busys = 0, wrs = 0;
    tick(1'b1, 4'd5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 4'd0, 1'b0, 1'b0);
      shifts += int'(bus.shift);
      busys  += int'(bus.busy);
      wrs    += int'(bus.wr);
      total++;
      if (i < 5 && bus.cnt !== 4'(5 - i)) begin
        bad++;
        $display("FAIL basic_cnt[%0d]: got %0d required %0d", i, bus.cnt, 5 - i);
      end
      total++;
      if (bus.wr !== (i == 5)) begin
        bad++;
        $display("FAIL basic_wr[%0d]: got %b required %b", i, bus.wr, (i == 5));
      end
    end
    total++;
    if (shifts != 5 || busys != 5 || wrs != 1 || bus.busy !== 1'b0 || bus.cnt !== 4'd0) begin
      bad++;
      $display("FAIL basic_totals: shift=%0d busy=%0d wr=%0d required 5 5 1", shifts, busys, wrs);
    end
  endtask

  task automatic test_hold();
    int shifts = 0, busys = 0, wrs = 0;
    tick(1'b1, 4'd4, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      tick(1'b0, 4'd0, (j == 2 || j == 3), 1'b0);
      shifts += int'(bus.shift);
      busys  += int'(bus.busy);
      wrs    += int'(bus.wr);
      if (j == 3) begin
        total++;
        if (bus.cnt !== 4'd2 || bus.shift !== 1'b0 || bus.busy !== 1'b1) begin
          bad++;
          $display("FAIL hold_frozen: cnt=%0d shift=%b busy=%b required 2 0 1", bus.cnt, bus.shift, bus.busy);
        end
      end
    end
    total++;
    if (shifts != 4 || busys != 6 || wrs != 1) begin
      bad++;
      $display("FAIL hold_totals: shift=%0d busy=%0d wr=%0d required 4 6 1", shifts, busys, wrs);
    end
  endtask

  task automatic test_abort();
    int wrs = 0, shifts = 0;
    tick(1'b1, 4'd6, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      tick(1'b0, 4'd0, 1'b0, (j == 2));
      shifts += int'(bus.shift);
      wrs    += int'(bus.wr);
      if (j == 3) begin
        total++;
        if (bus.busy !== 1'b0 || bus.cnt !== 4'd0) begin
          bad++;
          $display("FAIL abort_idle: busy=%b cnt=%0d required 0 0", bus.busy, bus.cnt);
        end
      end
    end
    total++;
    if (wrs != 0 || shifts != 3) begin
      bad++;
      $display("FAIL abort_totals: wr=%0d shift=%0d required 0 3", wrs, shifts);
    end
    tick(1'b0, 4'd0, 1'b0, 1'b1);
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    total++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.wr !== 1'b0 || bus.cnt !== 4'd0) begin
      bad++;
      $display("FAIL abort_in_idle: busy=%b err=%b wr=%b cnt=%0d required 0 0 0 0",
               bus.busy, bus.err, bus.wr, bus.cnt);
    end
  endtask

`ifndef SHIFT_SEQ_PRELOAD_EN
  task automatic test_reject();
    int shifts = 0, errs = 0, wrs = 0;
    tick(1'b1, 4'd0, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    total++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reject_len0: err=%b busy=%b required 1 0", bus.err, bus.busy);
    end
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    total++;
    if (bus.err !== 1'b0) begin
      bad++;
      $display("FAIL reject_len0_pulse: err=%b required 0", bus.err);
    end
    tick(1'b1, 4'd5, 1'b0, 1'b0);
    for (int j = 0; j < 9; j++) begin
      tick((j == 1), 4'd3, 1'b0, 1'b0);
      shifts += int'(bus.shift);
      errs   += int'(bus.err);
      wrs    += int'(bus.wr);
    end
    total++;
    if (shifts != 5 || errs != 1 || wrs != 1) begin
      bad++;
      $display("FAIL reject_run: shift=%0d err=%0d wr=%0d required 5 1 1", shifts, errs, wrs);
    end
  endtask
`else
  task automatic test_preload();
    int shifts = 0, wrs = 0, errs = 0, first = -1, lastc = -1;
    tick(1'b1, 4'd3, 1'b0, 1'b0);
    for (int j = 0; j < 9; j++) begin
      tick((j == 0), 4'd2, 1'b0, 1'b0);
      if (bus.shift) begin
        shifts++;
        if (first < 0) first = j;
        lastc = j;
      end
      wrs  += int'(bus.wr);
      errs += int'(bus.err);
    end
    total++;
    if (shifts != 5 || lastc - first != 4 || wrs != 2 || errs != 0) begin
      bad++;
      $display("FAIL preload_chain: shift=%0d span=%0d wr=%0d err=%0d required 5 5 2 0",
               shifts, lastc - first + 1, wrs, errs);
    end
    errs = 0;
    tick(1'b1, 4'd5, 1'b0, 1'b0);
    tick(1'b1, 4'd2, 1'b0, 1'b0);
    tick(1'b1, 4'd4, 1'b0, 1'b0);
    for (int j = 0; j < 12; j++) begin
      tick(1'b0, 4'd0, 1'b0, 1'b0);
      errs += int'(bus.err);
    end
    total++;
    if (errs != 1) begin
      bad++;
      $display("FAIL preload_full: err=%0d required 1", errs);
    end
  endtask
`endif

  task automatic test_rst_midburst();
    int shifts = 0, wrs = 0;
    tick(1'b1, 4'd15, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) tick(1'b0, 4'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.shift, bus.wr, bus.err, bus.cnt} !== {4'b0000, 4'd0}) begin
      bad++;
      $display("FAIL rst_async: busy=%b shift=%b wr=%b err=%b cnt=%0d required all 0",
               bus.busy, bus.shift, bus.wr, bus.err, bus.cnt);
    end
    bus.load = 1'b1; bus.len = 4'd1;
    repeat (2) begin
      @(negedge clk);
      wrs += int'(bus.wr);
    end
    rst = 1'b0;
    @(posedge clk);
    #1 bus.load = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1 || bus.cnt !== 4'd1) begin
      bad++;
      $display("FAIL rst_first_load: busy=%b cnt=%0d required 1 1", bus.busy, bus.cnt);
    end
    shifts += int'(bus.shift);
    for (int j = 0; j < 4; j++) begin
      tick(1'b0, 4'd0, 1'b0, 1'b0);
      shifts += int'(bus.shift);
      wrs    += int'(bus.wr);
    end
    total++;
    if (shifts != 1 || wrs != 1) begin
      bad++;
      $display("FAIL rst_after_burst: shift=%0d wr=%0d required 1 1", shifts, wrs);
    end
  endtask

  // Reference: rem = shifts left in the active burst (0 = idle), pq holds
  // lengths waiting to follow it; outputs derived from that with plain ints.
  task automatic test_random();
    int rem = 0;
    int pq[$];
    bit exp_wr = 0, exp_err = 0;
    for (int c = 0; c < 600; c++) begin
      int r = int'($urandom_range(0, 99));
      logic a = (r < 3);
      logic h = !a && ($urandom_range(0, 3) == 0);
      logic l = !a && !h && ($urandom_range(0, 4) == 0);
      logic [CW-1:0] n = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      bit nwr = 0, nerr = 0;
      tick(l, n, h, a);
      total++;
      if (bus.busy !== (rem > 0) || bus.cnt !== 4'(rem) || bus.shift !== (rem > 0 && !h)
          || bus.wr !== exp_wr || bus.err !== exp_err) begin
        bad++;
        $display("FAIL random[%0d]: busy=%b cnt=%0d shift=%b wr=%b err=%b required %b %0d %b %b %b",
                 c, bus.busy, bus.cnt, bus.shift, bus.wr, bus.err,
                 (rem > 0), rem, (rem > 0 && !h), exp_wr, exp_err);
      end
      if (a) begin
        rem = 0;
        pq.delete();
      end else if (rem == 0) begin
        if (l) begin
          if (n == 0) nerr = 1;
          else rem = int'(n);
        end
      end else begin
        bit done = !h && rem == 1;
        if (!h) rem--;
        if (done) nwr = 1;
`ifdef SHIFT_SEQ_PRELOAD_EN
        if (l && (n == 0 || pq.size() != 0)) nerr = 1;
        if (done && pq.size() != 0) rem = pq.pop_front();
        else if (l && n != 0 && pq.size() == 0) begin
          if (done) rem = int'(n);
          else pq.push_back(int'(n));
        end
`else
        if (l) nerr = 1;
`endif
      end
      exp_wr  = nwr;
      exp_err = nerr;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    bus.load = 1'b0; bus.len = '0; bus.hold = 1'b0; bus.abort = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_abort();
`ifndef SHIFT_SEQ_PRELOAD_EN
    test_reject();
`else
    test_preload();
`endif
    test_rst_midburst();
    for (int k = 0; k < 20; k++) tick(1'b0, 4'd0, 1'b0, 1'b0);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter CW, default 4, width of length/count path (legal 2..16).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 load  input  1  request to start a shift burst of length len.
REQ-005 len  input  CW  burst length in shift cycles; sampled only when load=1.
REQ-006 hold  input  1  pause; freezes counter and suppresses shift while high.
REQ-007 abort  input  1  synchronous cancel of current burst.
REQ-008 shift  output  1  shift enable to datapath.
REQ-009 wr  output  1  single-cycle write strobe at burst completion.
REQ-010 busy  output  1  high while state is RUN.
REQ-011 cnt  output  CW  remaining shift cycles.
REQ-012 err  output  1  single-cycle pulse flagging a rejected load.

Function
REQ-013 Two states: IDLE, RUN; busy = (state==RUN).
REQ-014 shift SHALL be combinational: shift = busy & ~hold.
REQ-015 IDLE: load=1 with len!=0 -> cnt<=len, state RUN next cycle.
REQ-016 IDLE: load=1 with len==0 -> no state change, err=1 next cycle.
REQ-017 RUN, hold=0: cnt<=cnt-1 each cycle; exactly len shift cycles per burst when hold is never asserted.
REQ-018 RUN, hold=1: cnt and state unchanged, shift=0, wr not generated.
REQ-019 RUN, hold=0, cnt==1: cnt<=0, state<=IDLE, wr=1 in the following cycle only.
REQ-020 wr SHALL be registered and high for exactly one cycle per completed burst.
REQ-021 Counter never wraps: cnt==0 in RUN is unreachable; cnt holds 0 in IDLE.
REQ-022 abort=1: state<=IDLE, cnt<=0, no wr, any pending load discarded; abort overrides load, hold and completion in the same cycle.
REQ-023 abort in IDLE SHALL have no effect.
REQ-024 load while RUN (macro absent): rejected, err=1 next cycle, burst unaffected.
REQ-025 Priority, highest first: rst, abort, hold, completion/load.
REQ-026 Arithmetic is unsigned CW-bit; len maximum 2^CW-1.

Reset
REQ-027 While rst=1: state IDLE, cnt=0, wr=0, err=0, busy=0, shift=0, pending register empty.
REQ-028 rst asserted mid-burst SHALL abort immediately with no wr pulse; first legal load accepted on first rising edge after rst deasserts.

Configuration
REQ-029 Macro SHIFT_SEQ_PRELOAD_EN adds a one-deep pending-length register.
REQ-030 With macro: load during RUN with len!=0 and pending empty is stored, no err; at completion cnt<=pending, state stays RUN with no gap cycle, wr still pulses once, pending cleared.
REQ-031 With macro: load during RUN with pending full, or with len==0, SHALL pulse err and leave pending unchanged.
REQ-032 With macro: load coinciding with the completion cycle and pending empty SHALL reload directly (back-to-back).
REQ-033 Without macro: REQ-024 applies; no pending storage is synthesised.

Verification (CW=4)
REQ-034 load=1, len=5, hold=0 -> busy 5 cycles, shift 5 cycles, cnt 5,4,3,2,1, wr=1 one cycle after last shift, then IDLE.
REQ-035 len=4, hold=1 for 2 cycles after second shift -> shift total 4, busy 6 cycles, wr once.
REQ-036 len=6, abort on third shift cycle -> IDLE next cycle, cnt=0, wr never asserted.
REQ-037 load with len=0 in IDLE; then load len=3 during RUN (macro absent) -> err pulse each time, burst length unchanged.
REQ-038 Macro set: len=3, then load len=2 during RUN -> 5 contiguous shift cycles, two wr pulses; third load while pending full -> err.
REQ-039 rst asserted mid-burst len=15 -> all outputs 0 asynchronously, no wr; next load len=1 -> one shift, one wr.
